// File: rtl/prog_loader.sv
// Boot-time program loader: receives a length-prefixed byte image, writes 32-bit words
// into instruction memory and releases the CPU once the trailing XOR checksum matches.
module prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, RUN, ERR} state_t;

  state_t              state;
  logic [15:0]         n;
  logic [1:0]          byte_cnt;
  logic [ADDR_W-1:0]   word_idx;
  logic [23:0]         partial;
  logic [7:0]          csum;

  logic                take;
  logic [15:0]         n_hdr;
  logic                oversize;
  logic                last_word;

  assign take      = rx_valid && rx_ready;
  assign n_hdr     = {rx_data, n[7:0]};
  assign oversize  = {1'b0, n_hdr} > MAX_WORDS;
  assign last_word = (16'(word_idx) == (n - 16'd1));

  // Status outputs packed as {rx_ready, cpu_rst, done, err}, registered with the state.
  function automatic logic [3:0] flags_of(input state_t s);
    case (s)
      RUN:     flags_of = 4'b0010;
      ERR:     flags_of = 4'b0101;
      default: flags_of = 4'b1100;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                         <= HDR0;
      {rx_ready, cpu_rst, done, err} <= flags_of(HDR0);
      mem_we                        <= 1'b0;
      mem_addr                      <= '0;
      mem_wdata                     <= '0;
      n                             <= '0;
      byte_cnt                      <= '0;
      word_idx                      <= '0;
      partial                       <= '0;
      csum                          <= '0;
    end else begin
      mem_we <= 1'b0;
      if (take) begin
        case (state)
          HDR0: begin
            n[7:0]                        <= rx_data;
            state                         <= HDR1;
            {rx_ready, cpu_rst, done, err} <= flags_of(HDR1);
          end
          HDR1: begin
            n[15:8] <= rx_data;
            if (oversize) begin
              state                         <= ERR;
              {rx_ready, cpu_rst, done, err} <= flags_of(ERR);
            end else if (n_hdr == 16'd0) begin
              state                         <= CSUM;
              {rx_ready, cpu_rst, done, err} <= flags_of(CSUM);
            end else begin
              state                         <= DATA;
              {rx_ready, cpu_rst, done, err} <= flags_of(DATA);
            end
          end
          DATA: begin
            csum     <= csum ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: partial[7:0]   <= rx_data;
              2'd1: partial[15:8]  <= rx_data;
              2'd2: partial[23:16] <= rx_data;
              default: begin
                mem_we    <= 1'b1;
                mem_wdata <= {rx_data, partial};
                mem_addr  <= word_idx;
                word_idx  <= word_idx + 1'b1;
                if (last_word) begin
                  state                         <= CSUM;
                  {rx_ready, cpu_rst, done, err} <= flags_of(CSUM);
                end
              end
            endcase
          end
          CSUM: begin
            if (rx_data == csum) begin
              state                         <= RUN;
              {rx_ready, cpu_rst, done, err} <= flags_of(RUN);
            end else begin
              state                         <= ERR;
              {rx_ready, cpu_rst, done, err} <= flags_of(ERR);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a byte-stream model predicts status and write strobes
// each cycle, and directed images pin the model with hand-computed results.
module tb_prog_loader;
  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [31:0] mem_img [0:MAX_WORDS-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted byte so far; status follows from the stream format.
  logic [7:0]        acc[$];
  logic              exp_we = 1'b0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [31:0]       exp_wdata = '0;
  logic              took = 1'b0;

  function automatic logic [3:0] exp_flags();
    int k, nw, total;
    logic [7:0] x;
    k = acc.size();
    if (k < 2) return 4'b1100;
    nw = int'(acc[0]) + 256 * int'(acc[1]);
    if (nw > MAX_WORDS) return 4'b0101;
    total = 3 + 4 * nw;
    if (k < total) return 4'b1100;
    x = 8'h00;
    for (int i = 2; i < total - 1; i++) x = x ^ acc[i];
    return (acc[total-1] == x) ? 4'b0010 : 4'b0101;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [3:0] f;
    int k, nw;
    if (rst) begin
      acc.delete();
      exp_we = 1'b0;
      took   = 1'b0;
    end else begin
      f      = exp_flags();
      took   = 1'b0;
      exp_we = 1'b0;
      if (rx_valid && f[3]) begin
        acc.push_back(rx_data);
        took = 1'b1;
        k    = acc.size() - 1;
        if (k >= 2) begin
          nw = int'(acc[0]) + 256 * int'(acc[1]);
          if (nw <= MAX_WORDS && (k - 2) < 4 * nw && ((k - 2) % 4) == 3) begin
            exp_we    = 1'b1;
            exp_addr  = ADDR_W'((k - 2) / 4);
            exp_wdata = {acc[k], acc[k-1], acc[k-2], acc[k-3]};
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [3:0] f;
    f = exp_flags();
    chk("rx_ready", 32'(rx_ready), 32'(f[3]));
    chk("cpu_rst",  32'(cpu_rst),  32'(f[2]));
    chk("done",     32'(done),     32'(f[1]));
    chk("err",      32'(err),      32'(f[0]));
    chk("mem_we",   32'(mem_we),   32'(exp_we));
    if (exp_we) begin
      chk("mem_addr",  32'(mem_addr), 32'(exp_addr));
      chk("mem_wdata", mem_wdata, exp_wdata);
    end
    if (mem_we) begin
      mem_img[mem_addr] = mem_wdata;
      wr_cnt++;
    end
  end

  task automatic clear_img();
    for (int i = 0; i < MAX_WORDS; i++) mem_img[i] = 32'hDEAD_BEEF;
    wr_cnt = 0;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mem_addr",  32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata,     32'h0);
    chk("rst_mem_we",    32'(mem_we),   32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_img();
  endtask

  // mode 0: always valid, 1: valid toggles every cycle, 2: random gaps.
  task automatic send(input logic [7:0] img[$], input int mode);
    int phase;
    logic [3:0] f;
    phase = 0;
    foreach (img[i]) begin
      int budget;
      budget = 0;
      took   = 1'b0;
      forever begin
        f = exp_flags();
        if (!f[3]) begin
          rx_valid = 1'b0;
          return;
        end
        case (mode)
          0:       rx_valid = 1'b1;
          1:       rx_valid = (phase == 0);
          default: rx_valid = ($urandom_range(0, 2) != 0);
        endcase
        rx_data = rx_valid ? img[i] : 8'($urandom);
        @(posedge clk);
        #1;
        phase = 1 - phase;
        if (took) break;
        budget++;
        if (budget > 50) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: byte %0d not accepted, got none expected accept", i);
          rx_valid = 1'b0;
          return;
        end
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Junk traffic while in a terminal state must not be consumed.
  task automatic idle_junk(input int n);
    repeat (n) begin
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] img[$];
    logic [7:0] x;
    logic [31:0] last_word;
    int nw, mode;
    bit good, big;

    do_reset();
    chk("reset_rx_ready", 32'(rx_ready), 32'h1);
    chk("reset_cpu_rst",  32'(cpu_rst),  32'h1);
    chk("reset_done",     32'(done),     32'h0);
    chk("reset_err",      32'(err),      32'h0);

    // Two-word image with correct checksum.
    img = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
    send(img, 0);
    settle(3);
    chk("t1_wr_cnt", 32'(wr_cnt), 32'd2);
    chk("t1_word0",  mem_img[0],  32'h0000_0013);
    chk("t1_word1",  mem_img[1],  32'h0000_006F);
    chk("t1_done",   32'(done),   32'h1);
    chk("t1_cpu_rst", 32'(cpu_rst), 32'h0);
    idle_junk(8);
    chk("t1_done_hold", 32'(done), 32'h1);

    // Same image, bad checksum.
    do_reset();
    img[10] = 8'h7D;
    send(img, 0);
    settle(3);
    chk("t2_wr_cnt",  32'(wr_cnt),   32'd2);
    chk("t2_err",     32'(err),      32'h1);
    chk("t2_cpu_rst", 32'(cpu_rst),  32'h1);
    chk("t2_done",    32'(done),     32'h0);
    chk("t2_ready",   32'(rx_ready), 32'h0);
    idle_junk(6);

    // Oversize header N = 1025.
    do_reset();
    img = {8'h01, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    send(img, 0);
    idle_junk(10);
    chk("t3_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("t3_err",    32'(err),    32'h1);

    // Empty image, good and bad checksum.
    do_reset();
    img = {8'h00, 8'h00, 8'h00};
    send(img, 0);
    settle(2);
    chk("t4a_done",   32'(done),   32'h1);
    chk("t4a_wr_cnt", 32'(wr_cnt), 32'd0);
    do_reset();
    img = {8'h00, 8'h00, 8'h01};
    send(img, 0);
    settle(2);
    chk("t4b_err",    32'(err),    32'h1);
    chk("t4b_wr_cnt", 32'(wr_cnt), 32'd0);

    // Two-word image with valid toggling every cycle.
    do_reset();
    img = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
    send(img, 1);
    settle(3);
    chk("t5_wr_cnt", 32'(wr_cnt), 32'd2);
    chk("t5_word0",  mem_img[0],  32'h0000_0013);
    chk("t5_word1",  mem_img[1],  32'h0000_006F);
    chk("t5_done",   32'(done),   32'h1);

    // Asynchronous reset mid-payload, then full reload.
    do_reset();
    img = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F};
    send(img, 0);
    chk("t6_partial_wr", 32'(wr_cnt), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_cpu_rst", 32'(cpu_rst),  32'h1);
    chk("t6_async_ready",   32'(rx_ready), 32'h1);
    #4 rst = 1'b0;
    clear_img();
    img = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
    send(img, 0);
    settle(3);
    chk("t6_wr_cnt", 32'(wr_cnt), 32'd2);
    chk("t6_word0",  mem_img[0],  32'h0000_0013);
    chk("t6_done",   32'(done),   32'h1);

    // Full-capacity image N = MAX_WORDS.
    do_reset();
    img = {8'(MAX_WORDS & 255), 8'(MAX_WORDS >> 8)};
    x = 8'h00;
    for (int i = 0; i < 4 * MAX_WORDS; i++) begin
      img.push_back(8'($urandom));
      x = x ^ img[img.size()-1];
    end
    last_word = {img[img.size()-1], img[img.size()-2], img[img.size()-3], img[img.size()-4]};
    img.push_back(x);
    send(img, 0);
    settle(3);
    chk("t7_wr_cnt", 32'(wr_cnt), 32'(MAX_WORDS));
    chk("t7_last",   mem_img[MAX_WORDS-1], last_word);
    chk("t7_done",   32'(done), 32'h1);

    // Random images, gaps and checksum errors.
    for (int t = 0; t < 14; t++) begin
      do_reset();
      big  = ($urandom_range(0, 6) == 0);
      mode = $urandom_range(0, 2);
      if (big) begin
        nw  = $urandom_range(MAX_WORDS + 1, 65535);
        img = {8'(nw & 255), 8'(nw >> 8)};
        send(img, mode);
        idle_junk(5);
        chk("rand_big_err", 32'(err),    32'h1);
        chk("rand_big_wr",  32'(wr_cnt), 32'd0);
      end else begin
        nw  = $urandom_range(0, 6);
        img = {8'(nw), 8'h00};
        x   = 8'h00;
        for (int i = 0; i < 4 * nw; i++) begin
          img.push_back(8'($urandom));
          x = x ^ img[img.size()-1];
        end
        good = ($urandom_range(0, 3) != 0);
        img.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
        send(img, mode);
        settle(3);
        chk("rand_done", 32'(done),   32'(good));
        chk("rand_err",  32'(err),    32'(!good));
        chk("rand_wr",   32'(wr_cnt), 32'(nw));
        idle_junk(4);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-002 Parameter ADDR_W SHALL be: default 10, word-address width of instruction memory; capacity MAX_WORDS = 2**ADDR_W.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 rx_data  input  8  incoming program byte.
REQ-006 rx_valid  input  1  rx_data holds a valid byte.
REQ-007 rx_ready  output  1  loader can accept a byte this cycle.
REQ-008 mem_we  output  1  one-cycle write strobe to instruction memory.
REQ-009 mem_addr  output  ADDR_W  word address of the write.
REQ-010 mem_wdata  output  32  assembled instruction word.
REQ-011 cpu_rst  output  1  reset to the CPU core, high while loading or failed.
REQ-012 done  output  1  image loaded and checksum matched.
REQ-013 err  output  1  image rejected (oversize or checksum mismatch).

Function
REQ-014 A byte SHALL be accepted only in a cycle with rx_valid=1 and rx_ready=1; rx_valid without rx_ready SHALL be ignored.
REQ-015 Stream format SHALL be: count low byte, count high byte (N, 16-bit little-endian word count), then 4*N payload bytes, then one checksum byte.
REQ-016 States SHALL be HDR0, HDR1, DATA, CSUM, RUN, ERR; reset state HDR0.
REQ-017 rx_ready SHALL be 1 in HDR0, HDR1, DATA, CSUM and 0 in RUN and ERR.
REQ-018 HDR0: accepted byte -> N[7:0], go HDR1.
REQ-019 HDR1: accepted byte -> N[15:8]; if N > MAX_WORDS go ERR; if N = 0 go CSUM; else go DATA.
REQ-020 DATA: payload bytes SHALL be assembled little-endian (first byte -> bits 7:0, fourth -> bits 31:24) using a 2-bit byte counter.
REQ-021 On acceptance of the fourth byte of a word, the next cycle SHALL present mem_we=1 for exactly one cycle with mem_wdata = assembled word and mem_addr = word index (first word at 0).
REQ-022 Word index SHALL increment by 1 after each write; after word N-1's fourth byte is accepted, state SHALL go CSUM (same edge that raises mem_we).
REQ-023 A running XOR SHALL cover payload bytes only, cleared at reset, header bytes excluded.
REQ-024 CSUM: accepted byte equal to running XOR -> RUN; unequal -> ERR.
REQ-025 cpu_rst SHALL be 0 only in RUN; done SHALL be 1 only in RUN; err SHALL be 1 only in ERR.
REQ-026 RUN and ERR SHALL be terminal; only rst leaves them; input bytes in those states are not consumed.
REQ-027 Gaps in rx_valid at any point SHALL stall progress without altering state, counters, or checksum.
REQ-028 mem_we SHALL never assert outside the cycle following a completed word; no write occurs for N=0 or oversize N.

Reset
REQ-029 While rst=1 and on release: state HDR0, rx_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, err=0, N=0, byte counter=0, word index=0, XOR=0.
REQ-030 rst asserted mid-load SHALL abort immediately (asynchronous); a subsequent load restarts from HDR0 at address 0; memory contents already written are not cleared.

Verification
REQ-031 Bytes 02 00 13 00 00 00 6F 00 00 00 7C continuously valid -> writes addr0=0x00000013, addr1=0x0000006F; then done=1, cpu_rst=0, err=0.
REQ-032 Same image, checksum byte 0x7D -> both writes occur; then err=1, cpu_rst=1, done=0, rx_ready=0.
REQ-033 ADDR_W=10, header 01 04 (N=1025) -> ERR after second byte, no mem_we ever.
REQ-034 Header 00 00 then checksum 00 -> RUN with zero writes; checksum 01 -> ERR.
REQ-035 REQ-031 image with rx_valid toggled 1/0 every cycle -> identical writes and final state; each mem_we exactly one cycle.
REQ-036 rst pulsed after 5 payload bytes of REQ-031, then full REQ-031 image resent -> writes restart at addr0, done=1 at end.
